// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST initiator: drives the wrapper's test port over all addresses and
// latches the first mismatch (element, address, observed word). Every output is registered.
module mbist_march_ctrl #(
  parameter int addr = 3,
  parameter int data = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [data-1:0] mem_dout,
  output logic            test_mode,
  output logic            mbist_rd,
  output logic            mbist_wr,
  output logic [addr-1:0] mbist_addr,
  output logic [data-1:0] mbist_din,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic [2:0]      fail_elem,
  output logic [addr-1:0] fail_addr,
  output logic [data-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, M0_WR, RD, CMP_WR, M5_RD, M5_CMP, DONE} state_t;

  localparam logic [addr-1:0] LAST = '1;
  localparam logic [data-1:0] B0   = '0;
  localparam logic [data-1:0] B1   = '1;

  state_t          state;
  logic [2:0]      elem;
  logic            desc;
  logic            elem_end;
  logic            mismatch;
  logic [data-1:0] exp_val;
  logic [data-1:0] wr_val;

  // mbist_addr doubles as the address counter; M5 (elem 5) expects B0 like M1/M3
  always_comb begin
    desc     = (elem == 3'd3) || (elem == 3'd4);
    elem_end = desc ? (mbist_addr == '0) : (mbist_addr == LAST);
    exp_val  = ((elem == 3'd2) || (elem == 3'd4)) ? B1 : B0;
    wr_val   = ((elem == 3'd1) || (elem == 3'd3)) ? B1 : B0;
    mismatch = (mem_dout != exp_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      elem       <= '0;
      test_mode  <= 1'b0;
      mbist_rd   <= 1'b0;
      mbist_wr   <= 1'b0;
      mbist_addr <= '0;
      mbist_din  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_elem  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      mbist_rd  <= 1'b0;
      mbist_wr  <= 1'b0;
      mbist_din <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= M0_WR;
            elem       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            test_mode  <= 1'b1;
            fail       <= 1'b0;
            fail_elem  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            mbist_addr <= '0;
            mbist_wr   <= 1'b1;
            mbist_din  <= B0;
          end
        end
        M0_WR: begin
          if (mbist_addr == LAST) begin
            state      <= RD;
            elem       <= 3'd1;
            mbist_addr <= '0;
            mbist_rd   <= 1'b1;
          end else begin
            mbist_addr <= mbist_addr + 1'b1;
            mbist_wr   <= 1'b1;
            mbist_din  <= B0;
          end
        end
        RD: begin
          state     <= CMP_WR;
          mbist_wr  <= 1'b1;
          mbist_din <= wr_val;
        end
        CMP_WR, M5_CMP: begin
          if (mismatch) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            test_mode <= 1'b0;
            fail      <= 1'b1;
            fail_elem <= elem;
            fail_addr <= mbist_addr;
            fail_data <= mem_dout;
          end else if (state == M5_CMP && elem_end) begin
            state     <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            test_mode <= 1'b0;
          end else if (state == M5_CMP) begin
            state      <= M5_RD;
            mbist_addr <= mbist_addr + 1'b1;
            mbist_rd   <= 1'b1;
          end else if (elem_end) begin
            // descending elements 3 and 4 start from the top address
            state      <= (elem == 3'd4) ? M5_RD : RD;
            elem       <= elem + 3'd1;
            mbist_addr <= ((elem == 3'd2) || (elem == 3'd3)) ? LAST : '0;
            mbist_rd   <= 1'b1;
          end else begin
            state      <= RD;
            mbist_addr <= desc ? (mbist_addr - 1'b1) : (mbist_addr + 1'b1);
            mbist_rd   <= 1'b1;
          end
        end
        M5_RD: begin
          state <= M5_CMP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty-memory model, March C- reference scoreboard, protocol monitor.
module tb_mbist_march_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_dout = 8'h00;
  logic       test_mode, mbist_rd, mbist_wr, busy, done, fail;
  logic [2:0] mbist_addr, fail_elem, fail_addr;
  logic [7:0] mbist_din, fail_data;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.addr(3), .data(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_dout(mem_dout),
    .test_mode(test_mode), .mbist_rd(mbist_rd), .mbist_wr(mbist_wr),
    .mbist_addr(mbist_addr), .mbist_din(mbist_din),
    .busy(busy), .done(done), .fail(fail),
    .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  typedef struct packed {logic rd; logic wr; logic [2:0] a; logic [7:0] d;} op_t;
  typedef struct packed {logic fl; logic [2:0] elem; logic [2:0] a; logic [7:0] d; logic [15:0] cycles;} res_t;

  op_t  opq[$];
  res_t resq[$];
  int   total = 0;
  int   passed = 0;

  // fault: 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 masked bits cannot fall, 4 masked bits cannot rise
  int         ftype = 0;
  logic [2:0] faddr = 3'd0;
  logic [7:0] fmask = 8'h00;
  logic       mem_clear = 1'b0;
  logic [7:0] tmem [N];

  function automatic logic [7:0] fwrite(input logic [2:0] a, input logic [7:0] old, input logic [7:0] d);
    if (a != faddr) return d;
    case (ftype)
      1:       return d | fmask;
      2:       return d & ~fmask;
      3:       return d | (old & fmask);
      4:       return d & (old | ~fmask);
      default: return d;
    endcase
  endfunction

  // test memory: dout registered on the read edge, as the wrapper's test_mem does
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < N; i++) tmem[i] <= 8'h00;
    end else if (mbist_wr && test_mode) begin
      tmem[mbist_addr] <= fwrite(mbist_addr, tmem[mbist_addr], mbist_din);
    end
    if (mbist_rd && test_mode) mem_dout <= tmem[mbist_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference: walk March C- over an array, recording the expected access trace and outcome
  task automatic model_run();
    logic [7:0] m [N];
    res_t       r;
    op_t        o;
    logic [2:0] a;
    logic [7:0] ev, nv, rv;
    bit         stop;
    stop = 0;
    r = '0;
    r.cycles = 16'(N);
    for (int i = 0; i < N; i++) m[i] = 8'h00;
    for (int i = 0; i < N; i++) begin
      a = 3'(i);
      o = {1'b0, 1'b1, a, 8'h00};
      opq.push_back(o);
      m[i] = fwrite(a, m[i], 8'h00);
    end
    for (int e = 1; e <= 5 && !stop; e++) begin
      for (int i = 0; i < N && !stop; i++) begin
        a  = (e == 3 || e == 4) ? 3'(N - 1 - i) : 3'(i);
        ev = (e == 2 || e == 4) ? 8'hFF : 8'h00;
        rv = m[a];
        o  = {1'b1, 1'b0, a, 8'h00};
        opq.push_back(o);
        if (e < 5) begin
          nv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
          o  = {1'b0, 1'b1, a, nv};
          opq.push_back(o);
          m[a] = fwrite(a, m[a], nv);
        end
        r.cycles = r.cycles + 16'd2;
        if (rv != ev) begin
          stop   = 1;
          r.fl   = 1'b1;
          r.elem = 3'(e);
          r.a    = a;
          r.d    = rv;
        end
      end
    end
    resq.push_back(r);
  endtask

  // monitor: protocol, access trace and end-of-run results
  logic rst_prev = 1'b0;
  logic done_prev = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    op_t  e;
    res_t r;
    if (rst_prev) begin
      check("reset_outputs", {1'b0, test_mode, mbist_rd, mbist_wr, mbist_addr, mbist_din, busy, done,
                              fail, fail_elem, fail_addr, fail_data}, 32'd0);
      opq.delete();
      resq.delete();
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      check("protocol", {29'd0, mbist_rd & mbist_wr, ~test_mode & (mbist_rd | mbist_wr),
                         ~mbist_wr & (mbist_din != 8'h00)}, 32'd0);
      if (mbist_rd || mbist_wr) begin
        if (opq.size() == 0) check("op_unexpected", {mbist_rd, mbist_wr, mbist_addr, mbist_din}, 32'd0);
        else begin
          e = opq.pop_front();
          check("access", {mbist_rd, mbist_wr, mbist_addr, mbist_din}, e);
        end
      end
      if (done && !done_prev) begin
        if (resq.size() == 0) check("result_unexpected", done, 32'd0);
        else begin
          r = resq.pop_front();
          check("fail", fail, r.fl);
          check("fail_elem", fail_elem, r.elem);
          check("fail_addr", fail_addr, r.a);
          check("fail_data", fail_data, r.d);
          check("busy_cycles", busy_cnt, r.cycles);
          check("done_idle_outputs", {busy, test_mode}, 32'd0);
        end
        busy_cnt = 0;
      end
    end
    rst_prev  = rst;
    done_prev = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch();
    mem_clear = 1'b1;
    tick(1);
    mem_clear = 1'b0;
    model_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      tick(1);
      k++;
    end
    check("done_reached", done, 32'd1);
    tick(3);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    launch();
    wait_done();
    ftype = 1; faddr = 3'd5; fmask = 8'h01;
    launch();
    wait_done();
    ftype = 3; faddr = 3'd3; fmask = 8'hFF;
    launch();
    wait_done();
    ftype = 4; faddr = 3'd3; fmask = 8'hFF;
    launch();
    wait_done();
    // relaunch from a failing DONE with a start pulse while busy
    ftype = 0;
    launch();
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done();
    // reset in the middle of element 3
    launch();
    tick(5 * N + 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    launch();
    wait_done();
    for (int r = 0; r < 12; r++) begin
      ftype = int'($urandom_range(0, 4));
      faddr = 3'($urandom_range(0, N - 1));
      fmask = 8'($urandom_range(1, 255));
      launch();
      wait_done();
    end
    check("ops_drained", opq.size(), 32'd0);
    check("results_drained", resq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
